// File: rtl/ocmem_arb.sv
// Two-requester arbiter in front of a single-port on-chip memory.
// Alternating priority, bounded exclusive lock, one-cycle read response routing.
module ocmem_arb #(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic                  req0_lock_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [MEM_WIDTH-1:0]  req0_d_i,
  output logic                  rsp0_valid_o,
  output logic [MEM_WIDTH-1:0]  rsp0_q_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_we_i,
  input  logic                  req1_lock_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [MEM_WIDTH-1:0]  req1_d_i,
  output logic                  rsp1_valid_o,
  output logic [MEM_WIDTH-1:0]  rsp1_q_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_WIDTH-1:0]  mem_d_o,
  input  logic [MEM_WIDTH-1:0]  mem_q_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  // Value the counter reaches on the last cycle an owner may keep the port.
  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  state_t     state_r, state_s;
  logic       last_gnt_r, last_gnt_s;
  logic [7:0] lock_cnt_r, lock_cnt_s;
  logic       rd_pend_r, rd_pend_s;
  logic       tag_r, tag_s;
  logic       gnt0_s, gnt1_s, forced_s;

  // Grant selection, lock tracking and next-state decode
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    forced_s   = 1'b0;
    state_s    = state_r;
    last_gnt_s = last_gnt_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          gnt0_s = last_gnt_r;
          gnt1_s = ~last_gnt_r;
        end else begin
          gnt0_s = req0_valid_i;
          gnt1_s = req1_valid_i;
        end
        if (gnt0_s && req0_lock_i) begin
          state_s    = OWN0;
          lock_cnt_s = 8'd0;
        end else if (gnt1_s && req1_lock_i) begin
          state_s    = OWN1;
          lock_cnt_s = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0: begin
        gnt0_s     = req0_valid_i;
        lock_cnt_s = lock_cnt_r + 8'd1;
        if (!req0_lock_i) begin
          state_s = IDLE;
        end else if (lock_cnt_s == LOCK_LAST) begin
          state_s  = IDLE;
          forced_s = 1'b1;
        end else begin
          state_s = OWN0;
        end
      end
      OWN1: begin
        gnt1_s     = req1_valid_i;
        lock_cnt_s = lock_cnt_r + 8'd1;
        if (!req1_lock_i) begin
          state_s = IDLE;
        end else if (lock_cnt_s == LOCK_LAST) begin
          state_s  = IDLE;
          forced_s = 1'b1;
        end else begin
          state_s = OWN1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // Readys must be low for the whole reset window, not just after an edge.
    if (rst_i) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      gnt0_s = gnt0_s;
      gnt1_s = gnt1_s;
    end
    if (gnt0_s) begin
      last_gnt_s = 1'b0;
    end else if (gnt1_s) begin
      last_gnt_s = 1'b1;
    end else begin
      last_gnt_s = last_gnt_r;
    end
    // A forced release hands the next contended cycle to the other side.
    if (forced_s) begin
      last_gnt_s = (state_r == OWN1);
    end else begin
      last_gnt_s = last_gnt_s;
    end
  end

  // Read-response bookkeeping: one pending flag plus the requester tag
  always_comb begin
    rd_pend_s = (gnt0_s && !req0_we_i) || (gnt1_s && !req1_we_i);
    if (rd_pend_s) begin
      tag_s = gnt1_s;
    end else begin
      tag_s = tag_r;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
      lock_cnt_r <= 8'd0;
      rd_pend_r  <= 1'b0;
      tag_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_gnt_r <= last_gnt_s;
      lock_cnt_r <= lock_cnt_s;
      rd_pend_r  <= rd_pend_s;
      tag_r      <= tag_s;
    end
  end

  assign req0_ready_o = gnt0_s;
  assign req1_ready_o = gnt1_s;
  assign mem_ce_o     = gnt0_s | gnt1_s;
  assign mem_we_o     = (gnt0_s & req0_we_i) | (gnt1_s & req1_we_i);
  assign mem_addr_o   = gnt0_s ? req0_addr_i : (gnt1_s ? req1_addr_i : {ADDR_WIDTH{1'b0}});
  assign mem_d_o      = gnt0_s ? req0_d_i : (gnt1_s ? req1_d_i : {MEM_WIDTH{1'b0}});

  assign rsp0_valid_o = rd_pend_r & ~tag_r;
  assign rsp1_valid_o = rd_pend_r & tag_r;
  assign rsp0_q_o     = rsp0_valid_o ? mem_q_i : {MEM_WIDTH{1'b0}};
  assign rsp1_q_o     = rsp1_valid_o ? mem_q_i : {MEM_WIDTH{1'b0}};

endmodule

// File: tb/tb_ocmem_arb.sv
// Directed vector bench for ocmem_arb (MAX_LOCK=4) with a behavioural
// synchronous-read memory model on the shared port.
module tb_ocmem_arb;

  localparam logic [31:0] D10 = 32'h1111_0010;
  localparam logic [31:0] D20 = 32'h2222_0020;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] CF  = 32'hCAFE_0001;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req0_ready_o, req0_we_i, req0_lock_i;
  logic [9:0]  req0_addr_i;
  logic [31:0] req0_d_i;
  logic        rsp0_valid_o;
  logic [31:0] rsp0_q_o;
  logic        req1_valid_i, req1_ready_o, req1_we_i, req1_lock_i;
  logic [9:0]  req1_addr_i;
  logic [31:0] req1_d_i;
  logic        rsp1_valid_o;
  logic [31:0] rsp1_q_o;
  logic        mem_ce_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_d_o;
  logic [31:0] mem_q_i;

  logic [31:0] mem_r [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  // Single-port memory: write on enable+we, registered read otherwise.
  always @(posedge clk_i) begin
    if (mem_ce_o) begin
      if (mem_we_o) mem_r[mem_addr_o] <= mem_d_o;
      else          mem_q_i <= mem_r[mem_addr_o];
    end
  end

  ocmem_arb #(.MEM_WIDTH(32), .ADDR_WIDTH(10), .MAX_LOCK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_lock_i(req0_lock_i), .req0_addr_i(req0_addr_i), .req0_d_i(req0_d_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_q_o(rsp0_q_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_lock_i(req1_lock_i), .req1_addr_i(req1_addr_i), .req1_d_i(req1_d_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_q_o(rsp1_q_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_d_o(mem_d_o), .mem_q_i(mem_q_i)
  );

  typedef struct {
    logic v0, v1, we0, we1, lk0, lk1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic r0, r1, ce, we;
    logic [9:0]  addr;
    logic [31:0] md;
    logic rv0, rv1;
    logic [31:0] q0, q1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v0, logic v1, logic we0, logic we1, logic lk0, logic lk1,
                              logic [9:0] a0, logic [9:0] a1, logic [31:0] d0, logic [31:0] d1,
                              logic r0, logic r1, logic ce, logic we, logic [9:0] addr,
                              logic [31:0] md, logic rv0, logic rv1, logic [31:0] q0,
                              logic [31:0] q1);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.we0 = we0; v.we1 = we1; v.lk0 = lk0; v.lk1 = lk1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.ce = ce; v.we = we; v.addr = addr; v.md = md;
    v.rv0 = rv0; v.rv1 = rv1; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic we0, input logic we1,
                       input logic lk0, input logic lk1, input logic [9:0] a0,
                       input logic [9:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    req0_valid_i = v0; req1_valid_i = v1; req0_we_i = we0; req1_we_i = we1;
    req0_lock_i = lk0; req1_lock_i = lk1; req0_addr_i = a0; req1_addr_i = a1;
    req0_d_i = d0; req1_d_i = d1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_r[i] = 32'd0;
    mem_r[10'h010] = D10;
    mem_r[10'h020] = D20;
    mem_q_i = 32'd0;

    // Alternating reads, write-then-read, lock of req1, lock hold of req0 with valid low.
    for (int k = 0; k < 4; k++) begin
      vq.push_back(mk(1,1,0,0,0,0,10'h010,10'h020,0,0,
                      (k%2==0),(k%2==1),1,0,(k%2==0)?10'h010:10'h020,0,
                      (k%2==1),(k==2),(k%2==1)?D10:32'd0,(k==2)?D20:32'd0));
    end
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,D20));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(1,0,1,0,0,0,10'h005,0,DB,0, 1,0,1,1,10'h005,DB, 0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,10'h005,0,CF, 0,1,1,0,10'h005,CF, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,DB));
    vq.push_back(mk(1,0,0,0,0,0,10'h010,0,0,0, 1,0,1,0,10'h010,0, 0,0,0,0));
    vq.push_back(mk(1,1,0,0,0,1,10'h010,10'h020,0,0, 0,1,1,0,10'h020,0, 1,0,D10,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1,1,0,0,0,1,10'h010,10'h020,0,0, 0,1,1,0,10'h020,0, 0,1,0,D20));
    vq.push_back(mk(1,1,0,0,0,1,10'h010,10'h020,0,0, 1,0,1,0,10'h010,0, 0,1,0,D20));
    vq.push_back(mk(1,1,0,0,0,1,10'h010,10'h020,0,0, 0,1,1,0,10'h020,0, 1,0,D10,0));
    vq.push_back(mk(1,1,0,0,0,0,10'h010,10'h020,0,0, 0,1,1,0,10'h020,0, 0,1,0,D20));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,D20));
    vq.push_back(mk(1,1,0,0,1,0,10'h010,10'h020,0,0, 1,0,1,0,10'h010,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0,0,10'h020,0,0, 0,0,0,0,0,0, 1,0,D10,0));
    vq.push_back(mk(0,1,0,0,1,0,0,10'h020,0,0, 0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,10'h020,0,0, 0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,10'h020,0,0, 0,1,1,0,10'h020,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,D20));

    // Reset with valids applied: everything must stay quiet.
    rst_i = 1'b1;
    drive(1,1,1,1,0,0,10'h001,10'h002,32'h1,32'h2);
    #3;
    chk("rst.rdy0", {31'd0, req0_ready_o}, 32'd0);
    chk("rst.rdy1", {31'd0, req1_ready_o}, 32'd0);
    chk("rst.ce",   {31'd0, mem_ce_o}, 32'd0);
    chk("rst.we",   {31'd0, mem_we_o}, 32'd0);
    chk("rst.rv",   {30'd0, rsp0_valid_o, rsp1_valid_o}, 32'd0);
    drive(0,0,0,0,0,0,0,0,0,0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    foreach (vq[i]) begin
      @(posedge clk_i); #1;
      drive(vq[i].v0, vq[i].v1, vq[i].we0, vq[i].we1, vq[i].lk0, vq[i].lk1,
            vq[i].a0, vq[i].a1, vq[i].d0, vq[i].d1);
      #3;
      chk($sformatf("v%0d.rdy0", i), {31'd0, req0_ready_o}, {31'd0, vq[i].r0});
      chk($sformatf("v%0d.rdy1", i), {31'd0, req1_ready_o}, {31'd0, vq[i].r1});
      chk($sformatf("v%0d.ce", i),   {31'd0, mem_ce_o}, {31'd0, vq[i].ce});
      chk($sformatf("v%0d.we", i),   {31'd0, mem_we_o}, {31'd0, vq[i].we});
      chk($sformatf("v%0d.addr", i), {22'd0, mem_addr_o}, {22'd0, vq[i].addr});
      chk($sformatf("v%0d.md", i),   mem_d_o, vq[i].md);
      chk($sformatf("v%0d.rv0", i),  {31'd0, rsp0_valid_o}, {31'd0, vq[i].rv0});
      chk($sformatf("v%0d.rv1", i),  {31'd0, rsp1_valid_o}, {31'd0, vq[i].rv1});
      chk($sformatf("v%0d.q0", i),   rsp0_q_o, vq[i].q0);
      chk($sformatf("v%0d.q1", i),   rsp1_q_o, vq[i].q1);
    end

    // Reset mid-lock with a read in flight, asserted between clock edges.
    @(posedge clk_i); #1;
    drive(1,1,0,0,1,0,10'h010,10'h020,0,0);
    #3 chk("r25.gnt0", {30'd0, req0_ready_o, req1_ready_o}, 32'd2);
    @(posedge clk_i); #1;
    chk("r25.rv0_pre", {31'd0, rsp0_valid_o}, 32'd1);
    chk("r25.owned",   {31'd0, req1_ready_o}, 32'd0);
    #1 rst_i = 1'b1;
    #1;
    chk("r25.rv0_drop", {31'd0, rsp0_valid_o}, 32'd0);
    chk("r25.q0_drop",  rsp0_q_o, 32'd0);
    chk("r25.rdy_drop", {30'd0, req0_ready_o, req1_ready_o}, 32'd0);
    chk("r25.ce_drop",  {31'd0, mem_ce_o}, 32'd0);
    drive(1,1,0,0,0,0,10'h010,10'h020,0,0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;
    #2;
    chk("r25.no_rsp",   {30'd0, rsp0_valid_o, rsp1_valid_o}, 32'd0);
    chk("r25.pref0",    {30'd0, req0_ready_o, req1_ready_o}, 32'd2);
    @(posedge clk_i); #1;
    chk("r25.next1",    {30'd0, req0_ready_o, req1_ready_o}, 32'd1);
    chk("r25.rsp_new",  rsp0_q_o, D10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
